// File: rtl/runway_scheduler.sv
// Runway sequencer: arbitrates 16 slots (emergency fixed-priority, else round-robin)
// and walks the grantee through OFFER -> OCCUPIED -> GAP with forced release on stall.
module runway_scheduler #(
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic [15:0] emerg,
   input  logic        ack,
   input  logic        done,
   output logic [3:0]  grant_idx,
   output logic        grant_vld,
   output logic        busy,
   output logic        timeout
);

   typedef enum logic [1:0] {IDLE, OFFER, OCCUPIED, GAP} state_t;

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_LIM_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       ptr_q, ptr_d;
   logic [3:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             gvld_q, busy_q;

   logic [15:0] emg_req;
   logic        emg_any;
   logic [3:0]  emg_idx, rr_idx, rr_pos;

   // Both searches iterate from lowest to highest priority so the last hit wins.
   always_comb begin
      emg_req = req & emerg;
      emg_any = |emg_req;
      emg_idx = '0;
      for (int i = 15; i >= 0; i--)
         if (emg_req[i]) emg_idx = 4'(i);
      rr_idx = '0;
      rr_pos = '0;
      for (int k = 16; k >= 1; k--) begin
         rr_pos = ptr_q + 4'(k);
         if (req[rr_pos]) rr_idx = rr_pos;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               idx_d   = emg_any ? emg_idx : rr_idx;
               cnt_d   = '0;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (ack) begin
               state_d = OCCUPIED;
               ptr_d   = idx_q;
               cnt_d   = ONE;
            end else if (!req[idx_q]) begin
               state_d = IDLE;
            end else if (cnt_q == TO_LIM_M1) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         OCCUPIED: begin
            // done is checked first so it beats a timeout on the limit cycle
            if (done) begin
               state_d = GAP;
               cnt_d   = ONE;
            end else if (cnt_q == TO_LIM) begin
               timeout_d = 1'b1;
               state_d   = GAP;
               cnt_d     = ONE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LIM) state_d = IDLE;
            else                  cnt_d   = cnt_q + ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 4'hF;
         idx_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         gvld_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         gvld_q    <= (state_d == OFFER);
         busy_q    <= (state_d == OCCUPIED);
      end
   end

   assign grant_idx = idx_q;
   assign grant_vld = gvld_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_runway_scheduler.sv
// Scoreboard bench for runway_scheduler: driver pushes expected grantees from a
// behavioural arbiter model, a negedge monitor pops them on each new offer.
module tb_runway_scheduler;

   localparam int GAP = 4;
   localparam int TO  = 255;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] req = '0;
   logic [15:0] emerg = '0;
   logic        ack = 1'b0;
   logic        done = 1'b0;
   logic [3:0]  grant_idx;
   logic        grant_vld, busy, timeout;

   runway_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .emerg(emerg), .ack(ack), .done(done),
      .grant_idx(grant_idx), .grant_vld(grant_vld), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_pass = 0;
   int   to_seen = 0;
   int   m_ptr = 15;
   int   last_win = 0;
   int   exp_q[$];
   logic gv_prev = 1'b0;

   task automatic chk(input string nm, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
   endtask

   // Reference arbiter: lowest emergency requester, else first requester after the last ack.
   function automatic int model_win(input logic [15:0] r, input logic [15:0] e, input int p);
      for (int i = 0; i < 16; i++)
         if (r[i] && e[i]) return i;
      for (int k = 1; k <= 16; k++)
         if (r[(p + k) % 16]) return (p + k) % 16;
      return -1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (grant_vld && !gv_prev) begin
            if (exp_q.size() == 0) chk("grant_unexpected", int'(grant_idx), -1);
            else                   chk("grant_idx", int'(grant_idx), exp_q.pop_front());
         end
         if (timeout) to_seen++;
      end
      gv_prev = grant_vld;
   end

   task automatic expect_grant();
      last_win = model_win(req, emerg, m_ptr);
      exp_q.push_back(last_win);
   endtask

   task automatic wait_grant(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!grant_vld && lat < 1000);
      if (!grant_vld) chk("grant_wait_expired", int'(grant_vld), 1);
   endtask

   task automatic do_ack(input int wait_n, input bit dn);
      repeat (wait_n) @(negedge clk);
      ack  = 1'b1;
      done = dn;
      @(negedge clk);
      ack  = 1'b0;
      done = 1'b0;
      chk("busy_after_ack", int'(busy), 1);
      chk("gvld_after_ack", int'(grant_vld), 0);
      m_ptr = last_win;
   endtask

   task automatic do_occ(input int occ);
      repeat (occ - 1) @(negedge clk);
      chk("busy_before_done", int'(busy), 1);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("busy_after_done", int'(busy), 0);
      chk("no_timeout_on_done", int'(timeout), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      emerg = '0;
      m_ptr = 15;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, c;
      logic [15:0] r, w;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_grant_idx", int'(grant_idx), 0);
      chk("rst_grant_vld", int'(grant_vld), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_timeout", int'(timeout), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single requester, 1-cycle grant latency, 3-cycle occupancy, GAP then re-grant
      req = 16'h0001;
      expect_grant();
      wait_grant(lat);
      chk("grant_latency", lat, 1);
      do_ack(0, 1'b0);
      do_occ(3);
      expect_grant();
      wait_grant(lat);
      chk("gap_latency", lat, GAP + 1);
      do_ack(0, 1'b0);
      do_occ(2);
      req = '0;

      // Round-robin with wrap from a fresh pointer
      do_reset();
      req = 16'h8421;
      for (int i = 0; i < 5; i++) begin
         expect_grant();
         wait_grant(lat);
         if (i == 0) chk("rr_first_latency", lat, 1);
         else        chk("rr_gap_latency", lat, GAP + 1);
         do_ack(0, 1'b0);
         do_occ(2);
      end

      // Emergency beats round-robin (pointer parked on slot 2 first)
      req = 16'h0004;
      expect_grant();
      wait_grant(lat);
      do_ack(0, 1'b0);
      do_occ(1);
      req   = 16'h00FF;
      emerg = 16'h0030;
      expect_grant();
      wait_grant(lat);
      do_ack(1, 1'b0);
      do_occ(1);
      emerg = '0;

      // Offer never acked: forced release, pointer left where it was
      req = 16'h0080;
      expect_grant();
      wait_grant(lat);
      c = 1;
      do begin
         @(negedge clk);
         if (grant_vld) c++;
      end while (grant_vld && c < 600);
      chk("offer_timeout_len", c, TO);
      chk("offer_timeout_pulse", int'(timeout), 1);
      req = 16'h0180;
      expect_grant();
      wait_grant(lat);
      chk("offer_regrant_latency", lat, 1);
      chk("timeout_one_cycle", int'(timeout), 0);
      do_ack(0, 1'b0);
      do_occ(1);

      // Occupant never finishes: forced release into GAP
      req = 16'h0100;
      expect_grant();
      wait_grant(lat);
      do_ack(0, 1'b0);
      c = 1;
      do begin
         @(negedge clk);
         if (busy) c++;
      end while (busy && c < 600);
      chk("occ_timeout_len", c, TO);
      chk("occ_timeout_pulse", int'(timeout), 1);
      expect_grant();
      @(negedge clk);
      chk("occ_timeout_one_cycle", int'(timeout), 0);
      chk("occ_timeout_in_gap", int'(grant_vld), 0);
      // done exactly on the limit cycle wins over the timeout
      wait_grant(lat);
      do_ack(0, 1'b0);
      do_occ(TO);
      req = '0;

      // Randomised traffic with emergencies, withdrawals and ack+done collisions
      for (int it = 0; it < 30; it++) begin
         req   = 16'($urandom_range(1, 16'hFFFF));
         emerg = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0;
         expect_grant();
         wait_grant(lat);
         if ($urandom_range(0, 4) == 0) begin
            w = 16'h1 << last_win;
            r = req & ~w & 16'($urandom);
            if (r == 16'h0) r = 16'h1 << ((last_win + 1) % 16);
            req = r;
            expect_grant();
            @(negedge clk);
            chk("withdraw_no_timeout", int'(timeout), 0);
            chk("withdraw_drops_offer", int'(grant_vld), 0);
            wait_grant(lat);
         end
         do_ack($urandom_range(0, 3), 1'($urandom_range(0, 1)));
         do_occ($urandom_range(1, 6));
      end
      req   = '0;
      emerg = '0;

      // Asynchronous reset mid-occupancy
      repeat (GAP + 2) @(negedge clk);
      req = 16'h0008;
      expect_grant();
      wait_grant(lat);
      do_ack(0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_grant_idx", int'(grant_idx), 0);
      chk("async_rst_grant_vld", int'(grant_vld), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_timeout", int'(timeout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 15;
      req   = 16'h0002;
      expect_grant();
      wait_grant(lat);
      chk("post_rst_latency", lat, 1);
      do_ack(0, 1'b0);
      do_occ(2);
      req = '0;
      repeat (GAP + 2) @(negedge clk);

      chk("timeout_pulse_count", to_seen, 2);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/runway_scheduler.md
# runway_scheduler

Sequencer that shares the single runway between 16 aircraft slots. It picks one requester per cycle window: emergencies first, otherwise round-robin. It drives the 4-bit slot index into the 4-to-16 one-hot decoder and walks the grantee through offer, occupancy and wake-separation phases. It also force-releases a slot that stalls.

## Interface
Parameters:
- GAP_CYCLES, 4: wake-separation cycles after each release; legal range 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 255: maximum cycles in OFFER or OCCUPIED before forced release; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the shared phase counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  16  per-slot request, level; held by the requester until acked or withdrawn.
- emerg  in  16  per-slot emergency qualifier; a bit only counts where the matching req bit is set.
- ack  in  1  grantee confirms runway entry; sampled only in OFFER.
- done  in  1  occupant has cleared the runway; sampled only in OCCUPIED.
- grant_idx  out  4  granted slot index, fed to the decoder.
- grant_vld  out  1  offer outstanding.
- busy  out  1  runway occupied.
- timeout  out  1  one-cycle pulse on forced release.

## Operation
- FSM states: IDLE, OFFER, OCCUPIED, GAP.
- Internal state: round-robin pointer ptr[3:0] (last acked slot) and phase counter cnt[CNT_W-1:0].
- Registered outputs:
  - grant_vld = (state==OFFER).
  - busy = (state==OCCUPIED).
  - grant_idx holds its last value in IDLE, OCCUPIED and GAP, so the decoder keeps showing the occupant and the last grantee.

IDLE:
- If req==0, stay in IDLE.
- Else, if any req&emerg bit is set, the lowest-index such slot wins (fixed priority).
- Else the round-robin winner is the first set req bit searching ptr+1, ptr+2, … modulo 16, wrapping 15→0.
- Load grant_idx with the winner, clear cnt, go to OFFER.

OFFER:
- ack=1: go to OCCUPIED, set ptr←grant_idx, set cnt←1.
- Else, req[grant_idx]=0 (withdrawn): go to IDLE. No gap, no timeout pulse.
- Else, cnt==TIMEOUT_CYCLES-1: pulse timeout, go to IDLE. ptr is unchanged.
- Else cnt++.

OCCUPIED:
- done=1: go to GAP, cnt←1.
- Else, cnt==TIMEOUT_CYCLES: pulse timeout, go to GAP, cnt←1.
- Else cnt++.

GAP:
- When cnt==GAP_CYCLES, go to IDLE. Else cnt++.
- GAP therefore lasts exactly GAP_CYCLES cycles.

Simultaneous and boundary events:
- ack and done in the same OFFER cycle: ack is taken, done is ignored.
- done in the same cycle the timeout limit is reached: done wins, no timeout pulse.
- ack or done outside its sampling state is ignored.
- The emergency path does not bypass GAP, OFFER or OCCUPIED, and does not preempt an occupant.
- Emergency grants update ptr on ack, like normal grants.
- A requester is never granted twice in a row while another non-emergency request is pending.
- req/emerg changes during OCCUPIED or GAP have no effect until the next IDLE evaluation.

Reset (rst_n low, asynchronous):
- state=IDLE, ptr=15 (first round-robin search starts at slot 0), cnt=0.
- grant_idx=0, grant_vld=0, busy=0, timeout=0.
- Reset mid-operation abandons any offer or occupancy immediately, with no timeout pulse.
- Release is synchronous to clk.

## Timing
- req seen in IDLE at edge N → grant_vld=1 and grant_idx valid after edge N (1-cycle latency).
- ack sampled at edge M → busy=1 and grant_vld=0 after edge M.
- done sampled at edge K → busy=0 after K; next possible grant_vld after edge K+GAP_CYCLES+1.
- Back-to-back throughput: one grant per (occupancy + GAP_CYCLES + 2) cycles.
- timeout is high for exactly the one cycle following the limiting edge.
- Forced-release limits:
  - OCCUPIED with no done: busy drops after TIMEOUT_CYCLES cycles.
  - OFFER with no ack: grant_vld drops after TIMEOUT_CYCLES cycles.

## Test plan
- Reset, then req=16'h0001 with ack one cycle after grant_vld and done 3 cycles later:
  - grant_idx=0 and grant_vld exactly 1 cycle after req; busy for 3 cycles.
  - Then GAP of 4 cycles, then IDLE.
- req=16'h8421 held, ack/done each grant:
  - Grant order is 0,5,10,15,0 (round-robin with wrap).
  - No slot repeats while others are pending.
- req=16'h00FF, emerg=16'h0030, with ptr=2: grant_idx=4 (lowest emergency), not 3.
- Slot 7 granted, ack never given, req held: grant_vld drops and timeout pulses once after TIMEOUT_CYCLES=255 cycles; ptr unchanged.
- Occupant gives no done:
  - busy drops and timeout pulses after 255 cycles, then GAP.
  - done driven on the limit cycle instead: no timeout pulse.
- rst_n pulsed low mid-OCCUPIED:
  - All outputs go to 0 asynchronously.
  - After release, req=16'h0002 yields grant_idx=1.
